// File: rtl/switch_pkg.sv
// Shared constants for the switch conditioning path: debounce FSM state codes and default timing.
// Latency: n/a (constants only).
// Backpressure: n/a (constants only).
package switch_pkg;

    // Per-bit debounce FSM encoding
    localparam logic [0:0] ST_STABLE = 1'b0;
    localparam logic [0:0] ST_COUNT  = 1'b1;

    // 20 ms of stable input at a 50 MHz clk
    localparam int DEBOUNCE_CYCLES_50MHZ = 1_000_000;

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: 2-flop synchroniser, then counter debounce with registered rise/fall pulses.
// Latency: step set up before edge 0 reaches sw_clean (and a pulse) on edge DEBOUNCE_CYCLES+1.
// Backpressure: none; free-running level conditioner with no flow control.
module debounce_bit
    import switch_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50MHZ,
    parameter logic RESET_LEVEL     = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sw_raw,
    output logic sw_clean,
    output logic sw_rise,
    output logic sw_fall
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    // The first mismatching cycle is already one stable cycle, so counting starts at 1;
    // reaching CNT_LAST means DEBOUNCE_CYCLES mismatching cycles have been seen at sync_s2.
    localparam logic [CNT_W-1:0] CNT_FIRST = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

    (* ASYNC_REG = "TRUE" *) logic sync_s1;
    (* ASYNC_REG = "TRUE" *) logic sync_s2;

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;

    // Bring the asynchronous switch level into clk; only sync_s2 is used downstream
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_s1 <= RESET_LEVEL;
            sync_s2 <= RESET_LEVEL;
        end else begin
            sync_s1 <= sw_raw;
            sync_s2 <= sync_s1;
        end
    end

    // Debounce FSM: accept a new level only after it has held for DEBOUNCE_CYCLES cycles
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_STABLE;
            cnt      <= '0;
            sw_clean <= RESET_LEVEL;
            sw_rise  <= 1'b0;
            sw_fall  <= 1'b0;
        end else begin
            sw_rise <= 1'b0;
            sw_fall <= 1'b0;
            case (state)
                ST_STABLE: begin
                    if (sync_s2 != sw_clean) begin
                        state <= ST_COUNT;
                        cnt   <= CNT_FIRST;
                    end else begin
                        cnt <= '0;
                    end
                end
                ST_COUNT: begin
                    if (sync_s2 == sw_clean) begin
                        // bounce back to the accepted level: restart from scratch
                        state <= ST_STABLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state    <= ST_STABLE;
                        cnt      <= '0;
                        sw_clean <= sync_s2;
                        sw_rise  <= sync_s2;
                        sw_fall  <= ~sync_s2;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_STABLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/switch_debounce.sv
// Conditions WIDTH raw switch levels into clean synchronous levels plus 1-cycle rise/fall pulses.
// Latency: DEBOUNCE_CYCLES+1 edges after the capturing edge; all bits independent.
// Backpressure: none; outputs are levels/pulses with no flow control.
module switch_debounce
    import switch_pkg::*;
#(
    parameter int   WIDTH           = 4,
    parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50MHZ,
    parameter logic RESET_LEVEL     = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_clean,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall
);

    // One independent synchroniser + debouncer per switch bit
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_LEVEL     (RESET_LEVEL)
        ) u_debounce_bit (
            .clk      (clk),
            .reset_n  (reset_n),
            .sw_raw   (sw_raw[i]),
            .sw_clean (sw_clean[i]),
            .sw_rise  (sw_rise[i]),
            .sw_fall  (sw_fall[i])
        );
    end

endmodule

// File: tb/tb_switch_debounce.sv
// Self-checking bench for switch_debounce: scoreboard of expected pulse cycles plus level checks.
// Latency: expected pulse lands DEBOUNCE_CYCLES+2 edges after the input is driven at a negedge.
// Backpressure: n/a.
module tb_switch_debounce;

    localparam int D   = 8;
    localparam int LAT = D + 2;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] sw_raw  = 4'hF;
    logic [3:0] sw_clean;
    logic [3:0] sw_rise;
    logic [3:0] sw_fall;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int         cyc;
        logic [3:0] rise;
        logic [3:0] fall;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    switch_debounce #(
        .WIDTH           (4),
        .DEBOUNCE_CYCLES (D),
        .RESET_LEVEL     (1'b0)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .sw_raw   (sw_raw),
        .sw_clean (sw_clean),
        .sw_rise  (sw_rise),
        .sw_fall  (sw_fall)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Called at a negedge right after driving sw_raw / releasing reset
    task automatic expect_pulse(input logic [3:0] r, input logic [3:0] f);
        exp_t e;
        e.cyc  = cyc + LAT;
        e.rise = r;
        e.fall = f;
        sb.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Bit 1 bounce: high 5, low 1, high 7, then low (never D stable cycles)
    task automatic bounce_bit1();
        sw_raw[1] = 1'b1;
        wait_cyc(5);
        sw_raw[1] = 1'b0;
        wait_cyc(1);
        sw_raw[1] = 1'b1;
        wait_cyc(7);
        sw_raw[1] = 1'b0;
    endtask

    // Pulse monitor: compare every observed pulse against the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                chk("pulse_missed", cyc, sb[0].cyc);
                void'(sb.pop_front());
            end
            if ((sw_rise | sw_fall) != 4'h0) begin
                if (sb.size() == 0) begin
                    chk("pulse_unexp", {24'd0, sw_rise, sw_fall}, 32'd0);
                end else if (sb[0].cyc != cyc) begin
                    chk("pulse_early", cyc, sb[0].cyc);
                end else begin
                    e = sb.pop_front();
                    chk("pulse_rise", sw_rise, e.rise);
                    chk("pulse_fall", sw_fall, e.fall);
                end
            end
        end
    end

    // Stimulus
    initial begin
        // 1: reset with all inputs high
        reset_n = 1'b0;
        sw_raw  = 4'hF;
        wait_cyc(3);
        chk("rst_clean", sw_clean, 4'h0);
        chk("rst_rise", sw_rise, 4'h0);
        chk("rst_fall", sw_fall, 4'h0);
        reset_n = 1'b1;
        expect_pulse(4'hF, 4'h0);
        wait_cyc(LAT - 1);
        chk("t1_clean_early", sw_clean, 4'h0);
        wait_cyc(1);
        chk("t1_clean", sw_clean, 4'hF);
        wait_cyc(2);

        // bring every bit back low
        sw_raw = 4'h0;
        expect_pulse(4'h0, 4'hF);
        wait_cyc(LAT + 2);
        chk("t2_pre", sw_clean, 4'h0);

        // 2: clean step on bit 0
        sw_raw = 4'h1;
        expect_pulse(4'h1, 4'h0);
        wait_cyc(LAT - 1);
        chk("t2_clean_early", sw_clean, 4'h0);
        wait_cyc(1);
        chk("t2_clean", sw_clean, 4'h1);
        wait_cyc(2);

        // 3: bounce on bit 1 is rejected
        bounce_bit1();
        wait_cyc(LAT + 2);
        chk("t3_clean", sw_clean, 4'h1);

        // 4: bounce, then a stable high of exactly D cycles, then stable low
        bounce_bit1();
        wait_cyc(1);
        sw_raw[1] = 1'b1;
        expect_pulse(4'h2, 4'h0);
        wait_cyc(D);
        sw_raw[1] = 1'b0;
        expect_pulse(4'h0, 4'h2);
        wait_cyc(3);
        chk("t4_high", sw_clean, 4'h3);
        wait_cyc(LAT);
        chk("t4_low", sw_clean, 4'h1);

        // 5: bits 2 and 3 move in opposite directions together
        sw_raw = 4'h9;
        expect_pulse(4'h8, 4'h0);
        wait_cyc(LAT + 2);
        chk("t5_pre", sw_clean, 4'h9);
        sw_raw = 4'h5;
        expect_pulse(4'h4, 4'h8);
        wait_cyc(LAT + 2);
        chk("t5_clean", sw_clean, 4'h5);

        // 6: reset while bit 1 is at count 5
        sw_raw = 4'h7;
        wait_cyc(7);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_async", sw_clean, 4'h0);
        wait_cyc(3);
        chk("t6_rst_clean", sw_clean, 4'h0);
        chk("t6_rst_rise", sw_rise, 4'h0);
        chk("t6_rst_fall", sw_fall, 4'h0);
        reset_n = 1'b1;
        expect_pulse(4'h7, 4'h0);
        wait_cyc(LAT - 1);
        chk("t6_clean_early", sw_clean, 4'h0);
        wait_cyc(1);
        chk("t6_clean", sw_clean, 4'h7);

        wait_cyc(4);
        chk("sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
